// File: rtl/out_drain_reg.sv
// Captures N signed partial-sum lanes in one edge and drains them one per cycle over a valid/ready port.
// Optional macro OUT_DRAIN_RELU_EN clamps negative lanes to zero at capture.
module out_drain_reg #(
    parameter int N         = 3,
    parameter int O_WIDTH   = 16,
    parameter int IDX_WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      clk_i,
    input  logic                      freg_rst_i,
    input  logic [N*O_WIDTH-1:0]      psum_i,
    input  logic                      cap_i,
    output logic                      cap_ready_o,
    output logic signed [O_WIDTH-1:0] out_data_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      out_last_o,
    output logic                      busy_o,
    output logic                      cap_drop_o
);

    typedef enum logic {IDLE, DRAIN} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);

    state_t                    state_q, state_d;
    logic [IDX_WIDTH-1:0]      idx_q, idx_d;
    logic signed [O_WIDTH-1:0] lane_q [N];
    logic                      load;
    logic                      cap_drop_q;

    function automatic logic signed [O_WIDTH-1:0] cond_lane(input logic signed [O_WIDTH-1:0] v);
`ifdef OUT_DRAIN_RELU_EN
        return v[O_WIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        load        = 1'b0;
        cap_ready_o = 1'b1;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        out_last_o  = 1'b0;
        out_data_o  = '0;
        case (state_q)
            IDLE: begin
                if (cap_i) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
                out_data_o  = lane_q[idx_q];
                out_last_o  = (idx_q == LAST_IDX);
                // A new capture is only taken as the final lane leaves, so streams abut with no bubble.
                cap_ready_o = out_last_o && out_ready_i;
                if (cap_i && cap_ready_o) begin
                    load  = 1'b1;
                    idx_d = '0;
                end else if (out_ready_i) begin
                    if (out_last_o) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge freg_rst_i) begin
        if (freg_rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cap_drop_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cap_drop_q <= cap_i && !cap_ready_o;
            if (load) begin
                for (int k = 0; k < N; k++) begin
                    lane_q[k] <= cond_lane(psum_i[k*O_WIDTH +: O_WIDTH]);
                end
            end
        end
    end

    assign cap_drop_o = cap_drop_q;

endmodule

// File: tb/tb_out_drain_reg.sv
// Bench for out_drain_reg (N=3, O_WIDTH=16): directed scenarios plus a random run against a queue model.
module tb_out_drain_reg;

    logic               clk = 1'b0;
    logic               rst;
    logic [47:0]        psum;
    logic               cap;
    logic               cap_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               rdy;
    logic               out_last;
    logic               busy;
    logic               cap_drop;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    out_drain_reg #(.N(3), .O_WIDTH(16)) dut (
        .clk_i       (clk),
        .freg_rst_i  (rst),
        .psum_i      (psum),
        .cap_i       (cap),
        .cap_ready_o (cap_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (rdy),
        .out_last_o  (out_last),
        .busy_o      (busy),
        .cap_drop_o  (cap_drop)
    );

    function automatic logic signed [15:0] relu(input logic signed [15:0] v);
`ifdef OUT_DRAIN_RELU_EN
        return (v < 0) ? 16'sd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic drive(input logic c, input logic signed [15:0] l0, input logic signed [15:0] l1,
                         input logic signed [15:0] l2, input logic r);
        cap  = c;
        psum = {l2, l1, l0};
        rdy  = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 0, 0, 0, 1'b0);
        #3;
        vectors++;
        if ({out_valid, out_last, busy, cap_ready, cap_drop} !== 5'b00010 || out_data !== 16'sd0) begin
            miscompares++;
            $display("FAIL reset: valid/last/busy/cap_ready/drop=%b data=%0d, expected 00010 data=0",
                     {out_valid, out_last, busy, cap_ready, cap_drop}, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        logic signed [15:0] exp [3];
        exp[0] = 16'sd5; exp[1] = relu(-16'sd2); exp[2] = 16'sd7;
        drive(1'b1, 16'sd5, -16'sd2, 16'sd7, 1'b1);
        vectors++;
        if (cap_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_idle_ready: got %b expected 1", cap_ready);
        end
        tick();
        cap = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== exp[i] || out_last !== (i == 2)) begin
                miscompares++;
                $display("FAIL basic_lane%0d: valid=%b busy=%b data=%0d last=%b, expected 1 1 %0d %b",
                         i, out_valid, busy, out_data, out_last, exp[i], (i == 2));
            end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || cap_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_idle_after: valid=%b busy=%b cap_ready=%b, expected 0 0 1",
                     out_valid, busy, cap_ready);
        end
    endtask

    task automatic test_stall;
        drive(1'b1, 16'sd1, 16'sd2, 16'sd3, 1'b1);
        tick();
        cap = 1'b0;
        vectors++;
        if (out_data !== 16'sd1) begin
            miscompares++;
            $display("FAIL stall_lane0: got %0d expected 1", out_data);
        end
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_data !== 16'sd2 || out_valid !== 1'b1 || out_last !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold%0d: data=%0d valid=%b last=%b, expected 2 1 0",
                         i, out_data, out_valid, out_last);
            end
            tick();
        end
        rdy = 1'b1;
        vectors++;
        if (out_data !== 16'sd2) begin
            miscompares++;
            $display("FAIL stall_resume: got %0d expected 2", out_data);
        end
        tick();
        vectors++;
        if (out_data !== 16'sd3 || out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_last: data=%0d last=%b, expected 3 1", out_data, out_last);
        end
        tick();
    endtask

    task automatic test_drop;
        drive(1'b1, 16'sd4, 16'sd5, 16'sd6, 1'b0);
        tick();
        drive(1'b1, 16'sd11, 16'sd12, 16'sd13, 1'b0);
        vectors++;
        if (cap_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_ready: got %b expected 0", cap_ready);
        end
        tick();
        drive(1'b0, 16'sd0, 16'sd0, 16'sd0, 1'b1);
        vectors++;
        if (cap_drop !== 1'b1 || out_data !== 16'sd4) begin
            miscompares++;
            $display("FAIL drop_pulse: drop=%b data=%0d, expected 1 4", cap_drop, out_data);
        end
        for (int i = 1; i < 3; i++) begin
            tick();
            vectors++;
            if (cap_drop !== 1'b0 || out_data !== 16'(4 + i)) begin
                miscompares++;
                $display("FAIL drop_after%0d: drop=%b data=%0d, expected 0 %0d", i, cap_drop, out_data, 4 + i);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic signed [15:0] exp [6];
        exp[0] = 16'sd1; exp[1] = 16'sd2; exp[2] = 16'sd3;
        exp[3] = 16'sd9; exp[4] = 16'sd8; exp[5] = 16'sd7;
        drive(1'b1, 16'sd1, 16'sd2, 16'sd3, 1'b1);
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 2) drive(1'b1, 16'sd9, 16'sd8, 16'sd7, 1'b1);
            else        drive(1'b0, 16'sd0, 16'sd0, 16'sd0, 1'b1);
            vectors++;
            if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i % 3 == 2)) begin
                miscompares++;
                $display("FAIL b2b_elem%0d: busy=%b valid=%b data=%0d last=%b, expected 1 1 %0d %b",
                         i, busy, out_valid, out_data, out_last, exp[i], (i % 3 == 2));
            end
            tick();
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 16'sd5, 16'sd6, 16'sd7, 1'b1);
        tick();
        cap = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 16'sd0 || cap_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b data=%0d cap_ready=%b busy=%b, expected 0 0 1 0",
                     out_valid, out_data, cap_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_after: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_random;
        logic signed [15:0] q [$];
        logic               m_drop;
        logic               m_rdy;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        m_drop = 1'b0;
        for (int c = 0; c < 400; c++) begin
            cap          = ($urandom_range(0, 9) < 3);
            rdy          = ($urandom_range(0, 9) < 7);
            psum[31:0]   = $urandom();
            psum[47:32]  = 16'($urandom());
            #1;
            m_rdy = (q.size() == 0) || (q.size() == 1 && rdy);
            vectors++;
            if (out_valid !== (q.size() != 0) || busy !== (q.size() != 0) || out_last !== (q.size() == 1)
                || cap_ready !== m_rdy || cap_drop !== m_drop) begin
                miscompares++;
                $display("FAIL rand_ctrl cyc%0d: valid=%b busy=%b last=%b ready=%b drop=%b, expected %b %b %b %b %b",
                         c, out_valid, busy, out_last, cap_ready, cap_drop,
                         (q.size() != 0), (q.size() != 0), (q.size() == 1), m_rdy, m_drop);
            end
            if (q.size() != 0) begin
                vectors++;
                if (out_data !== q[0]) begin
                    miscompares++;
                    $display("FAIL rand_data cyc%0d: got %0d expected %0d", c, out_data, q[0]);
                end
            end
            m_drop = cap && !m_rdy;
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (cap && m_rdy) begin
                q.delete();
                for (int k = 0; k < 3; k++) q.push_back(relu($signed(psum[k*16 +: 16])));
            end
            @(posedge clk);
            #1;
        end
        cap = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_drop();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/out_drain_reg.md
OUT_DRAIN_REG -- requirements
Module: out_drain_reg

Interface
REQ-001 SHALL have parameter N, default 3, meaning number of partial-sum lanes captured per load.
REQ-002 SHALL have parameter O_WIDTH, default 16, meaning signed width of each partial sum.
REQ-003 SHALL have parameter IDX_WIDTH, default $clog2(N) (minimum 1), meaning drain index width.
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port freg_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port psum_i  input  N*O_WIDTH  flattened signed lanes; lane k = bits [k*O_WIDTH +: O_WIDTH].
REQ-007 SHALL have port cap_i  input  1  capture request for all N lanes.
REQ-008 SHALL have port cap_ready_o  output  1  capture is accepted this cycle if cap_i high.
REQ-009 SHALL have port out_data_o  output  O_WIDTH signed  current drained element.
REQ-010 SHALL have port out_valid_o  output  1  out_data_o valid.
REQ-011 SHALL have port out_ready_i  input  1  downstream accepts element.
REQ-012 SHALL have port out_last_o  output  1  current element is lane N-1.
REQ-013 SHALL have port busy_o  output  1  drain in progress.
REQ-014 SHALL have port cap_drop_o  output  1  one-cycle registered pulse: capture request refused.

Function
REQ-015 SHALL implement two states: IDLE and DRAIN.
REQ-016 In IDLE, cap_ready_o SHALL be 1 and out_valid_o, out_last_o, busy_o SHALL be 0.
REQ-017 IDLE with cap_i=1 SHALL store all N lanes into internal registers, set index to 0 and enter DRAIN at the same edge.
REQ-018 In DRAIN, out_valid_o and busy_o SHALL be 1 and out_data_o SHALL equal stored lane[index], combinationally from registers.
REQ-019 Drain order SHALL be lane 0 first, lane N-1 last; out_last_o = 1 only when index = N-1.
REQ-020 Transfer occurs when out_valid_o and out_ready_i are both 1; the index SHALL advance by 1 on each transfer only.
REQ-021 While out_valid_o=1 and out_ready_i=0, out_data_o, out_last_o and the index SHALL hold stable.
REQ-022 On the transfer of lane N-1, the FSM SHALL return to IDLE, unless a capture occurs in the same cycle per REQ-023.
REQ-023 In DRAIN, cap_ready_o SHALL equal out_last_o AND out_ready_i; if cap_i=1 then, new lanes are stored, index resets to 0 and the FSM stays in DRAIN, giving back-to-back streams with no bubble.
REQ-024 Latency: a capture at edge t SHALL produce out_valid_o=1 in the cycle after edge t; each stream is N elements at 1 element/cycle under continuous out_ready_i.
REQ-025 When cap_i=1 and cap_ready_o=0, the request SHALL be ignored, stored data SHALL be unchanged, and cap_drop_o SHALL be 1 for exactly the following cycle.
REQ-026 For N=1, the single element SHALL carry out_last_o=1.
REQ-027 Stored lane values SHALL keep full O_WIDTH signed precision; no truncation or extension.

Reset
REQ-028 freg_rst_i=1 SHALL immediately force IDLE, index 0, all stored lanes 0 and cap_drop_o 0, independent of clk_i.
REQ-029 During and after reset, outputs SHALL be out_valid_o=0, out_data_o=0, out_last_o=0, busy_o=0, cap_ready_o=1.
REQ-030 Reset asserted mid-drain SHALL abort the stream; no further out_valid_o until a new capture after reset deassertion.

Configuration
REQ-031 When macro OUT_DRAIN_RELU_EN is defined, each lane SHALL be stored at capture as 0 if negative and unchanged otherwise.
REQ-032 When OUT_DRAIN_RELU_EN is undefined, lanes SHALL be stored unmodified, including negative values.

Verification (N=3, O_WIDTH=16)
REQ-033 Capture lanes {5,-2,7} with out_ready_i=1 held high -> outputs 5,-2,7 on 3 consecutive cycles starting 1 cycle after capture; out_last_o=1 only with 7; then IDLE. Value -2 becomes 0 when OUT_DRAIN_RELU_EN is defined.
REQ-034 Capture {1,2,3}, then out_ready_i=0 for 4 cycles on lane 1 -> out_data_o holds 2 and out_valid_o holds 1; resume -> 2,3 follow.
REQ-035 cap_i pulsed while index=0 in DRAIN -> stream continues unchanged; cap_drop_o=1 for exactly one cycle.
REQ-036 New capture {9,8,7} in the cycle lane 2 of the previous stream transfers -> 9 appears in the next cycle; busy_o never drops.
REQ-037 freg_rst_i asserted asynchronously mid-stream -> out_valid_o=0 and out_data_o=0 immediately; cap_ready_o=1.
